mole_round_ctrl: RTL and testbench
==================================

Name: mole_round_ctrl

Overview:
- Consumer end of the one-hot target generator used by the whack-a-mole game.
- Requests a new target from the generator and waits for it to settle, then validates it.
- Raises the matching mole LED and judges the player's button press as hit or miss within a time window.
- Keeps score and miss count, and ends the game after MAX_MISSES misses. Sits between the RNG, the debounced button inputs and the display/score logic.

Parameters:
- UP_CYCLES, 50000000: cycles a mole stays up before a timeout miss.
- GAP_CYCLES, 12500000: blank cycles between rounds.
- SETTLE_CYCLES, 2: cycles waited after the gen_req pulse before target is sampled.
- MAX_MISSES, 3: misses that end the game (must be 1 or more).
- SCORE_W, 8: score width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  level; sampled only in IDLE/OVER; starts a new game
- buttons  in  5  debounced, clock-synchronous, active-high; bit i = hole i
- target  in  5  one-hot hole index from the generator
- gen_req  out  1  one-cycle pulse; its rising edge triggers the generator
- mole_leds  out  5  one-hot lit mole; 0 when no mole is up
- hit  out  1  one-cycle pulse on a correct whack
- miss  out  1  one-cycle pulse on a wrong press or timeout
- score  out  SCORE_W  hits this game, saturating
- misses  out  $clog2(MAX_MISSES+1)  misses this game
- game_over  out  1  high in OVER
- busy  out  1  high in any state except IDLE/OVER

Behaviour:
- Reset values: all outputs 0; state IDLE; btn_prev=0; all counters 0.
- btn_prev <= buttons every cycle in every state. press = buttons & ~btn_prev. A button held across a state change never produces a press.
- Single cycle counter, width $clog2(max(UP_CYCLES,GAP_CYCLES,SETTLE_CYCLES)+1). Cleared on every state entry.
- IDLE:
  - start=1 -> score=0, misses=0, go to REQ.
- REQ (1 cycle):
  - gen_req=1 for this cycle only; go to SETTLE.
  - gen_req is never high two consecutive cycles.
- SETTLE:
  - Count SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (1 cycle):
  - target exactly one-hot -> mole_leds<=target (visible the next cycle), go to UP.
  - target is zero or multi-hot -> return to REQ, with no miss and no score change. Retries are unlimited.
- UP:
  - Any press bit outside mole_leds -> miss, regardless of a simultaneous correct bit.
  - Otherwise press & mole_leds nonzero -> hit.
  - Otherwise counter reaching UP_CYCLES-1 -> miss (timeout).
  - A correct press on the final timeout cycle counts as a hit.
  - On hit or miss:
    - mole_leds<=0 and the hit/miss pulse are registered for the next cycle.
    - score and misses update in that same cycle.
    - score saturates at 2^SCORE_W-1 (hit still pulses).
    - Go to OVER if the updated misses equals MAX_MISSES, else go to GAP.
- GAP:
  - Presses are ignored (no miss).
  - After GAP_CYCLES cycles go to REQ.
- OVER:
  - game_over=1; score and misses hold.
  - start=1 -> clear score/misses, go to REQ (game_over drops the next cycle).
- start is ignored outside IDLE/OVER.
- reset=1 in any state, including mid-UP: return to reset values at the next edge; no hit/miss pulse is emitted.
- hit and miss are never high in the same cycle.

Decomposition:
- Shared package mole_pkg holds:
  - the state enum (IDLE, REQ, SETTLE, CHECK, UP, GAP, OVER);
  - NUM_HOLES=5;
  - a function is_onehot(5-bit).
- Natural sub-module: btn_edge_detect (registered rising-edge detect, 5 bits). The FSM, counters and scoring stay in the top module.

Test Plan:
- Reset, then start=1, with the generator model returning 00100 -> gen_req pulses 1 cycle; after SETTLE_CYCLES, mole_leds=00100; press buttons[2] -> hit pulse, score=1, mole_leds=0, gap, then gen_req again.
- Mole 01000 up, press buttons[0] -> miss pulse, misses=1, score unchanged. Press buttons[3] together with buttons[1] -> miss.
- Mole up with no press, UP_CYCLES=8 -> miss exactly 8 cycles after mole_leds asserts. Correct press on cycle 8 -> hit instead.
- Generator returns 00000 then 10001 then 00010 -> two extra gen_req pulses, no miss, then mole_leds=00010.
- MAX_MISSES=3 with three timeouts -> game_over=1, misses=3, busy=0. start -> score/misses=0, game_over falls, new gen_req.
- Hold buttons[1] high from GAP into UP with mole 00010 -> no hit; release and re-press -> hit. Assert reset mid-UP -> all outputs 0, no pulse.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole round controller: hole count,
// FSM state encoding and small helper functions.
package mole_pkg;

    localparam int NUM_HOLES = 5;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETTLE,
        CHECK,
        UP,
        GAP,
        OVER
    } state_t;

    // True when exactly one hole bit is set.
    function automatic logic is_onehot(input logic [NUM_HOLES-1:0] v);
        return $countones(v) == 1;
    endfunction

    // Largest of three cycle counts; sizes the shared cycle counter.
    function automatic int max_of3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mole_round_ctrl_btn_edge_detect.sv
// Rising-edge detector for the debounced button bus. The previous sample is
// registered every cycle regardless of game state, so a button that is
// already held when a state is entered never reads as a fresh press.
module btn_edge_detect
    import mole_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_HOLES-1:0] buttons,
    output logic [NUM_HOLES-1:0] press
);

    logic [NUM_HOLES-1:0] btn_prev;

    // Remember last cycle's buttons.
    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
        if (reset) begin
            btn_prev <= '0;
        end else begin
            btn_prev <= buttons;
        end
    end

    assign press = buttons & ~btn_prev;

endmodule

// File: rtl/mole_round_ctrl.sv
// Round controller for the whack-a-mole game: requests a one-hot target from
// the generator, validates it, shows the mole, judges presses as hit or miss
// within the up window, keeps score/miss counts and ends the game after
// MAX_MISSES misses.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int UP_CYCLES     = 50000000,
    parameter int GAP_CYCLES    = 12500000,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_MISSES    = 3,
    parameter int SCORE_W       = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_HOLES-1:0]              buttons,
    input  logic [NUM_HOLES-1:0]              target,
    output logic                              gen_req,
    output logic [NUM_HOLES-1:0]              mole_leds,
    output logic                              hit,
    output logic                              miss,
    output logic [SCORE_W-1:0]                score,
    output logic [$clog2(MAX_MISSES+1)-1:0]   misses,
    output logic                              game_over,
    output logic                              busy
);

    localparam int MISS_W  = $clog2(MAX_MISSES + 1);
    localparam int CNT_MAX = max_of3(UP_CYCLES, GAP_CYCLES, SETTLE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   UP_LAST     = CNT_W'(UP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [MISS_W-1:0]  MISS_LIMIT  = MISS_W'(MAX_MISSES);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

    state_t               state;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_HOLES-1:0] press;
    logic                 wrong_press;
    logic                 right_press;
    logic [MISS_W-1:0]    misses_plus;
    logic                 hit_d;
    logic                 miss_d;
    logic                 clear_game;
    logic                 load_mole;

    btn_edge_detect u_btn_edge_detect (
        .clock   (clock),
        .reset   (reset),
        .buttons (buttons),
        .press   (press)
    );

    // A wrong bit anywhere overrides a simultaneous correct bit.
    assign wrong_press = |(press & ~mole_leds);
    assign right_press = |(press & mole_leds);
    assign misses_plus = misses + MISS_W'(1);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_d    = state;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        clear_game = 1'b0;
        load_mole  = 1'b0;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    clear_game = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (is_onehot(target)) begin
                    load_mole = 1'b1;
                    state_d   = UP;
                end else begin
                    state_d = REQ;
                end
            end
            UP: begin
                if (wrong_press) begin
                    miss_d = 1'b1;
                end else if (right_press) begin
                    hit_d = 1'b1;
                end else if (cnt == UP_LAST) begin
                    miss_d = 1'b1;
                end
                if (hit_d) begin
                    state_d = GAP;
                end else if (miss_d) begin
                    state_d = (misses_plus == MISS_LIMIT) ? OVER : GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Cycle counter, mole display, result pulses and game counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt       <= '0;
            mole_leds <= '0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            score     <= '0;
            misses    <= '0;
        end else begin
            if (state_d != state) begin
                cnt <= '0;
            end else if (state == SETTLE || state == UP || state == GAP) begin
                cnt <= cnt + CNT_W'(1);
            end

            hit  <= hit_d;
            miss <= miss_d;

            if (load_mole) begin
                mole_leds <= target;
            end else if (hit_d || miss_d) begin
                mole_leds <= '0;
            end

            if (clear_game) begin
                score  <= '0;
                misses <= '0;
            end else begin
                if (hit_d && score != SCORE_MAX) begin
                    score <= score + SCORE_W'(1);
                end
                if (miss_d) begin
                    misses <= misses_plus;
                end
            end
        end
    end

    assign gen_req   = (state == REQ);
    assign game_over = (state == OVER);
    assign busy      = (state != IDLE) && (state != OVER);

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl. Expected behaviour of each round is
// derived from the round timeline: REQ, SETTLE_CYCLES settle cycles, one check
// cycle, up window, result pulse, gap, next REQ.
module tb_mole_round_ctrl;

    localparam int UP_C  = 8;
    localparam int GAP_C = 4;
    localparam int SET_C = 2;
    localparam int MAXM  = 3;
    localparam int SW    = 3;
    localparam int MW    = $clog2(MAXM + 1);
    localparam int SMAX  = (1 << SW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [4:0]    buttons;
    logic [4:0]    target;
    logic          gen_req;
    logic [4:0]    mole_leds;
    logic          hit;
    logic          miss;
    logic [SW-1:0] score;
    logic [MW-1:0] misses;
    logic          game_over;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int exp_score = 0;
    int exp_misses = 0;

    mole_round_ctrl #(
        .UP_CYCLES     (UP_C),
        .GAP_CYCLES    (GAP_C),
        .SETTLE_CYCLES (SET_C),
        .MAX_MISSES    (MAXM),
        .SCORE_W       (SW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .buttons   (buttons),
        .target    (target),
        .gen_req   (gen_req),
        .mole_leds (mole_leds),
        .hit       (hit),
        .miss      (miss),
        .score     (score),
        .misses    (misses),
        .game_over (game_over),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full round starting at the cycle where gen_req is seen (c=0).
    // k < 0 means no press; pre_hold is held until one cycle before the press;
    // tail is driven during the gap that follows the result.
    task automatic play_round(input logic [4:0] mole, input logic [4:0] pre_hold,
                              input int k, input logic [4:0] bits,
                              input logic [4:0] tail, input string name);
        int   u, e, last, old_score, old_misses;
        logic is_hit, ends;
        logic [4:0] exp_leds;
        u = SET_C + 2;
        old_score  = exp_score;
        old_misses = exp_misses;
        is_hit = 1'b0;
        if (k >= 0 && (bits & ~mole) != 5'b0) begin
            e = u + k + 1;
        end else if (k >= 0 && (bits & mole) != 5'b0) begin
            is_hit = 1'b1;
            e = u + k + 1;
        end else begin
            e = u + UP_C;
        end
        if (is_hit) exp_score = (exp_score == SMAX) ? SMAX : exp_score + 1;
        else exp_misses = exp_misses + 1;
        ends = (exp_misses == MAXM);
        last = ends ? e : e + GAP_C;
        target = mole;
        for (int c = 1; c <= last; c++) begin
            step();
            if (c > e) buttons = tail;
            else if (k < 0) buttons = 5'b0;
            else if (c == u + k) buttons = bits;
            else if (c <= u + k - 2) buttons = pre_hold;
            else buttons = 5'b0;
            exp_leds = (c >= u && c < e) ? mole : 5'b0;
            checks++;
            if (mole_leds !== exp_leds) begin
                errors++;
                $display("FAIL %s mole_leds c=%0d got %b want %b", name, c, mole_leds, exp_leds);
            end
            checks++;
            if (hit !== (c == e && is_hit)) begin
                errors++;
                $display("FAIL %s hit c=%0d got %b want %b", name, c, hit, (c == e && is_hit));
            end
            checks++;
            if (miss !== (c == e && !is_hit)) begin
                errors++;
                $display("FAIL %s miss c=%0d got %b want %b", name, c, miss, (c == e && !is_hit));
            end
            checks++;
            if (gen_req !== (!ends && c == last)) begin
                errors++;
                $display("FAIL %s gen_req c=%0d got %b want %b", name, c, gen_req, (!ends && c == last));
            end
            if (c == e - 1) begin
                checks++;
                if (score !== SW'(old_score) || misses !== MW'(old_misses)) begin
                    errors++;
                    $display("FAIL %s early_update c=%0d got score=%0d misses=%0d want %0d/%0d",
                             name, c, score, misses, old_score, old_misses);
                end
            end
            if (c == e) begin
                checks++;
                if (score !== SW'(exp_score) || misses !== MW'(exp_misses)) begin
                    errors++;
                    $display("FAIL %s counters c=%0d got score=%0d misses=%0d want %0d/%0d",
                             name, c, score, misses, exp_score, exp_misses);
                end
                checks++;
                if (game_over !== ends || busy !== !ends) begin
                    errors++;
                    $display("FAIL %s over_flags c=%0d got game_over=%b busy=%b want %b/%b",
                             name, c, game_over, busy, ends, !ends);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        buttons = 5'b0;
        target = 5'b0;
        repeat (3) step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({gen_req, mole_leds, hit, miss, score, misses, game_over, busy} !== '0) begin
                errors++;
                $display("FAIL reset_state i=%0d got gen=%b leds=%b hit=%b miss=%b score=%0d misses=%0d over=%b busy=%b want all 0",
                         i, gen_req, mole_leds, hit, miss, score, misses, game_over, busy);
            end
            step();
        end
    endtask

    task automatic test_start(input string name);
        start = 1'b1;
        step();
        start = 1'b0;
        exp_score = 0;
        exp_misses = 0;
        checks++;
        if (gen_req !== 1'b1 || busy !== 1'b1 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL %s flags got gen=%b busy=%b over=%b want 1/1/0", name, gen_req, busy, game_over);
        end
        checks++;
        if (score !== '0 || misses !== '0) begin
            errors++;
            $display("FAIL %s clear got score=%0d misses=%0d want 0/0", name, score, misses);
        end
    endtask

    task automatic test_hit();
        play_round(5'b00100, 5'b0, 3, 5'b00100, 5'b0, "hit");
    endtask

    task automatic test_wrong_press();
        play_round(5'b01000, 5'b0, 2, 5'b00001, 5'b0, "wrong");
        play_round(5'b01000, 5'b0, 5, 5'b01010, 5'b0, "wrong_combo");
    endtask

    task automatic test_retry();
        int p;
        p = SET_C + 2;
        target = 5'b00000;
        buttons = 5'b0;
        for (int c = 1; c <= 2 * p; c++) begin
            step();
            checks++;
            if (gen_req !== (c == p || c == 2 * p)) begin
                errors++;
                $display("FAIL retry gen_req c=%0d got %b want %b", c, gen_req, (c == p || c == 2 * p));
            end
            checks++;
            if (miss !== 1'b0 || hit !== 1'b0 || mole_leds !== 5'b0) begin
                errors++;
                $display("FAIL retry quiet c=%0d got hit=%b miss=%b leds=%b want 0/0/0", c, hit, miss, mole_leds);
            end
            if (c == p) target = 5'b10001;
        end
        play_round(5'b00010, 5'b0, 1, 5'b00010, 5'b0, "retry_hit");
    endtask

    task automatic test_final_cycle_hit();
        play_round(5'b10000, 5'b0, UP_C - 1, 5'b10000, 5'b00010, "final_cycle_hit");
    endtask

    task automatic test_held_button();
        play_round(5'b00010, 5'b00010, 4, 5'b00010, 5'b0, "held_button");
    endtask

    task automatic test_timeout();
        play_round(5'b00001, 5'b0, -1, 5'b0, 5'b0, "timeout");
    endtask

    task automatic test_over_hold();
        for (int i = 0; i < 6; i++) begin
            buttons = 5'($urandom);
            step();
            checks++;
            if (game_over !== 1'b1 || busy !== 1'b0 || gen_req !== 1'b0 || hit !== 1'b0 ||
                miss !== 1'b0 || mole_leds !== 5'b0) begin
                errors++;
                $display("FAIL over_hold flags i=%0d got over=%b busy=%b gen=%b hit=%b miss=%b leds=%b want 1/0/0/0/0/0",
                         i, game_over, busy, gen_req, hit, miss, mole_leds);
            end
            checks++;
            if (score !== SW'(exp_score) || misses !== MW'(exp_misses)) begin
                errors++;
                $display("FAIL over_hold counters i=%0d got score=%0d misses=%0d want %0d/%0d",
                         i, score, misses, exp_score, exp_misses);
            end
        end
        buttons = 5'b0;
        step();
    endtask

    task automatic test_three_timeouts();
        for (int r = 0; r < MAXM; r++) begin
            play_round(5'b00001 << $urandom_range(0, 4), 5'b0, -1, 5'b0, 5'b0, "three_timeouts");
        end
    endtask

    task automatic test_random_rounds();
        int h, o, kind;
        logic [4:0] m, b;
        for (int r = 0; r < 30 && exp_misses < MAXM; r++) begin
            h = $urandom_range(0, 4);
            m = 5'b00001 << h;
            kind = (r < 9) ? 2 : $urandom_range(0, 5);
            if (r >= 24) kind = 0;
            if (kind == 0) begin
                play_round(m, 5'b0, -1, 5'b0, 5'b0, "rand_timeout");
            end else if (kind == 1) begin
                o = (h + $urandom_range(1, 4)) % 5;
                b = (5'b00001 << o) | (($urandom_range(0, 1) == 1) ? m : 5'b0);
                play_round(m, 5'b0, $urandom_range(0, UP_C - 1), b, 5'b0, "rand_wrong");
            end else begin
                play_round(m, 5'b0, $urandom_range(0, UP_C - 1), m, 5'b0, "rand_hit");
            end
        end
    endtask

    task automatic test_reset_mid_up();
        int u;
        u = SET_C + 2;
        target = 5'b00100;
        for (int c = 1; c <= u + 3; c++) step();
        checks++;
        if (mole_leds !== 5'b00100) begin
            errors++;
            $display("FAIL reset_mid_up pre got leds=%b want 00100", mole_leds);
        end
        buttons = 5'b00100;
        reset = 1'b1;
        step();
        reset = 1'b0;
        buttons = 5'b0;
        exp_score = 0;
        exp_misses = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({gen_req, mole_leds, hit, miss, score, misses, game_over, busy} !== '0) begin
                errors++;
                $display("FAIL reset_mid_up i=%0d got gen=%b leds=%b hit=%b miss=%b score=%0d misses=%0d over=%b busy=%b want all 0",
                         i, gen_req, mole_leds, hit, miss, score, misses, game_over, busy);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_start("start_idle");
        test_hit();
        test_wrong_press();
        test_retry();
        test_final_cycle_hit();
        test_held_button();
        test_timeout();
        test_over_hold();
        test_start("restart_over");
        test_three_timeouts();
        test_start("restart_two");
        test_random_rounds();
        test_start("restart_three");
        test_reset_mid_up();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
